// File: rtl/time_counter.sv
// 24 h time-of-day counter with 1 Hz run mode and debounced key1 field set mode.
// Optional AUTO_REPEAT_EN adds hold-to-repeat on key1 while in set mode.
`timescale 1ns/1ps
module time_counter #(
   parameter int unsigned CLK_FREQ        = 50_000_000,
   parameter int unsigned DEBOUNCE_MS     = 20,
   parameter int unsigned REPEAT_DELAY_MS = 500,
   parameter int unsigned REPEAT_RATE_MS  = 125
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       set_mode,
   input  logic [1:0] option,
   input  logic       add_key,
   output logic [4:0] hour,
   output logic [5:0] minute,
   output logic [5:0] second,
   output logic       sec_pulse
);
   localparam int unsigned DB_CYC = CLK_FREQ / 1000 * DEBOUNCE_MS;
   localparam int unsigned PW     = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
   localparam int unsigned DW     = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
   localparam logic [PW-1:0] PRESC_TC = PW'(CLK_FREQ - 1);
   localparam logic [DW-1:0] DB_LAST  = DW'(DB_CYC - 1);

   logic          key_s1_q, key_s2_q;
   logic          key_db_q, key_db_d;
   logic [DW-1:0] db_cnt_q, db_cnt_d;
   logic          press_q, press_d;
   logic          db_mis, db_flip;
   logic [PW-1:0] presc_q, presc_d;
   logic          tick, evt;
   logic [4:0]    hour_q, hour_d;
   logic [5:0]    min_q, min_d;
   logic [5:0]    sec_q, sec_d;
   logic          pulse_q;

   always_comb begin
      db_mis   = (key_s2_q != key_db_q);
      db_flip  = db_mis && (db_cnt_q == DB_LAST);
      db_cnt_d = (db_mis && !db_flip) ? db_cnt_q + 1'b1 : '0;
      key_db_d = db_flip ? key_s2_q : key_db_q;
      press_d  = db_flip & key_db_q;
   end

`ifdef AUTO_REPEAT_EN
   localparam int unsigned RPT_DLY  = CLK_FREQ / 1000 * REPEAT_DELAY_MS;
   localparam int unsigned RPT_RATE = CLK_FREQ / 1000 * REPEAT_RATE_MS;
   localparam int unsigned RPT_MAX  = (RPT_DLY > RPT_RATE) ? RPT_DLY : RPT_RATE;
   localparam int unsigned RW       = $clog2(RPT_MAX + 1);
   localparam logic [RW-1:0] DLY_LAST  = RW'(RPT_DLY - 1);
   localparam logic [RW-1:0] RATE_LAST = RW'(RPT_RATE - 1);

   logic          armed_q, armed_d;
   logic          first_q, first_d;
   logic          rep_q, rep_d;
   logic [RW-1:0] rcnt_q, rcnt_d;

   // Every strobe (press or repeat) restarts the interval count at 1, so the
   // next repeat lands exactly DELAY/RATE cycles after the previous strobe.
   always_comb begin
      armed_d = armed_q;
      first_d = first_q;
      rcnt_d  = rcnt_q;
      rep_d   = 1'b0;
      if (!set_mode || key_db_q) begin
         armed_d = 1'b0;
         first_d = 1'b1;
         rcnt_d  = '0;
      end else if (press_q || rep_q) begin
         armed_d = 1'b1;
         first_d = press_q;
         rcnt_d  = RW'(1);
      end else if (armed_q) begin
         rcnt_d = rcnt_q + 1'b1;
         rep_d  = (rcnt_q == (first_q ? DLY_LAST : RATE_LAST));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed_q <= 1'b0;
         first_q <= 1'b1;
         rep_q   <= 1'b0;
         rcnt_q  <= '0;
      end else begin
         armed_q <= armed_d;
         first_q <= first_d;
         rep_q   <= rep_d;
         rcnt_q  <= rcnt_d;
      end
   end

   assign evt = press_q | rep_q;
`else
   assign evt = press_q;
`endif

   always_comb begin
      tick    = ~set_mode & (presc_q == PRESC_TC);
      presc_d = (set_mode || tick) ? '0 : presc_q + 1'b1;
      hour_d  = hour_q;
      min_d   = min_q;
      sec_d   = sec_q;
      if (tick) begin
         if (sec_q == 6'd59) begin
            sec_d = '0;
            if (min_q == 6'd59) begin
               min_d  = '0;
               hour_d = (hour_q == 5'd23) ? '0 : hour_q + 5'd1;
            end else begin
               min_d = min_q + 6'd1;
            end
         end else begin
            sec_d = sec_q + 6'd1;
         end
      end else if (set_mode && evt) begin
         case (option)
            2'd0:    sec_d  = (sec_q == 6'd59)  ? '0 : sec_q + 6'd1;
            2'd1:    min_d  = (min_q == 6'd59)  ? '0 : min_q + 6'd1;
            2'd2:    hour_d = (hour_q == 5'd23) ? '0 : hour_q + 5'd1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_s1_q <= 1'b1;
         key_s2_q <= 1'b1;
         key_db_q <= 1'b1;
         db_cnt_q <= '0;
         press_q  <= 1'b0;
         presc_q  <= '0;
         hour_q   <= '0;
         min_q    <= '0;
         sec_q    <= '0;
         pulse_q  <= 1'b0;
      end else begin
         key_s1_q <= add_key;
         key_s2_q <= key_s1_q;
         key_db_q <= key_db_d;
         db_cnt_q <= db_cnt_d;
         press_q  <= press_d;
         presc_q  <= presc_d;
         hour_q   <= hour_d;
         min_q    <= min_d;
         sec_q    <= sec_d;
         pulse_q  <= tick;
      end
   end

   assign hour      = hour_q;
   assign minute    = min_q;
   assign second    = sec_q;
   assign sec_pulse = pulse_q;
endmodule
